// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch FSM feeding a small prefetch buffer
module fetch_unit #(
    parameter int XLEN = 32,
    parameter int ILEN = 32,
    parameter int DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    imem_req,
    output logic [XLEN-1:0]         imem_addr,
    input  logic                    imem_rvalid,
    input  logic [ILEN-1:0]         imem_rdata,
    input  logic                    redirect,
    input  logic [XLEN-1:0]         redirect_pc,
    output logic                    instr_valid,
    input  logic                    instr_ready,
    output logic [ILEN-1:0]         instr_data,
    output logic [XLEN-1:0]         instr_pc,
    output logic [$clog2(DEPTH):0]  fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

    state_t            state;
    logic [XLEN-1:0]   fetch_pc;
    logic [XLEN-1:0]   pc_inc;
    logic [XLEN-1:0]   new_pc;
    logic [XLEN-1:0]   pc_mem [DEPTH];
    logic [ILEN-1:0]   data_mem [DEPTH];
    logic [AW-1:0]     head;
    logic [AW-1:0]     tail;
    logic [CW-1:0]     count_next;
    logic              push;
    logic              pop;
    logic              room;

    // A response is only accepted in WAIT and only when no redirect kills it
    assign pop         = instr_valid & instr_ready;
    assign push        = (state == WAIT) & imem_rvalid & ~redirect;
    assign count_next  = fifo_count + CW'(push) - CW'(pop);
    assign room        = count_next < CW'(DEPTH);
    assign pc_inc      = fetch_pc + XLEN'(4);
    assign new_pc      = redirect_pc & ~XLEN'(3);
    assign instr_valid = fifo_count != '0;
    assign instr_data  = data_mem[head];
    assign instr_pc    = pc_mem[head];

    // Buffer storage; a slot is always reserved before a request starts
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail]   <= fetch_pc;
            data_mem[tail] <= imem_rdata;
        end
    end

    // Fetch FSM, pointers and occupancy; redirect overrides push and pop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            fetch_pc   <= RESET_PC;
            imem_addr  <= RESET_PC;
            imem_req   <= 1'b0;
            fifo_count <= '0;
            head       <= '0;
            tail       <= '0;
        end else if (redirect) begin
            fifo_count <= '0;
            head       <= tail;
            fetch_pc   <= new_pc;
            imem_req   <= 1'b1;
            if (state != IDLE && !imem_rvalid) begin
                state <= DISCARD;
            end else begin
                state     <= WAIT;
                imem_addr <= new_pc;
            end
        end else begin
            fifo_count <= count_next;
            head       <= head + AW'(pop);
            tail       <= tail + AW'(push);
            case (state)
                IDLE: if (room) begin
                    state     <= WAIT;
                    imem_addr <= fetch_pc;
                    imem_req  <= 1'b1;
                end
                WAIT: if (imem_rvalid) begin
                    fetch_pc <= pc_inc;
                    if (room) begin
                        imem_addr <= pc_inc;
                    end else begin
                        state    <= IDLE;
                        imem_req <= 1'b0;
                    end
                end
                DISCARD: if (imem_rvalid) begin
                    state     <= WAIT;
                    imem_addr <= fetch_pc;
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit with an address-tagged memory model
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req, imem_req2;
    logic [31:0] imem_addr, imem_addr2;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0, imem_rdata2 = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid, instr_valid2;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_data, instr_data2, instr_pc, instr_pc2;
    logic [2:0]  fifo_count, fifo_count2;

    int          pass_n = 0;
    int          total_n = 0;
    int          acc = 0;
    int          acc2 = 0;
    int          lat = 1;
    bit          stray = 1'b0;
    bit          chk2 = 1'b0;
    logic [31:0] q[$];
    logic [31:0] q2[$];

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect(redirect),
        .redirect_pc(redirect_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_data(instr_data), .instr_pc(instr_pc), .fifo_count(fifo_count)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst(rst), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata2), .redirect(redirect),
        .redirect_pc(redirect_pc), .instr_valid(instr_valid2), .instr_ready(instr_ready),
        .instr_data(instr_data2), .instr_pc(instr_pc2), .fifo_count(fifo_count2)
    );

    function automatic logic [31:0] tag(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic exp_seq(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) q.push_back(base + 32'(4 * i));
    endtask

    task automatic do_reset(input int l, input bit rdy);
        rst = 1'b0;
        redirect = 1'b0;
        instr_ready = rdy;
        lat = l;
        stray = 1'b0;
        chk2 = 1'b0;
        repeat (2) @(posedge clk);
        q.delete();
        q2.delete();
        acc = 0;
        acc2 = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Memory: answers a request after lat cycles with an address-tagged word
    initial begin : mem
        int cnt;
        bit lr;
        bit lv;
        cnt = 0;
        lr = 1'b0;
        lv = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (stray) begin
                imem_rvalid = 1'b1;
                imem_rdata = 32'hDEAD_BEEF;
                imem_rdata2 = 32'hDEAD_BEEF;
            end else begin
                if (imem_req && (!lr || lv)) cnt = lat;
                if (imem_req && cnt > 0) cnt--;
                imem_rvalid = imem_req && cnt == 0;
                imem_rdata = tag(imem_addr);
                imem_rdata2 = tag(imem_addr2);
            end
            lr = imem_req;
            lv = imem_rvalid;
        end
    end

    // Monitor: every accepted head entry must match the next expected PC
    initial begin : mon
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (rst && instr_valid && instr_ready) begin
                acc++;
                if (q.size() == 0) begin
                    total_n++;
                    $display("FAIL extra_output: got pc %h required none", instr_pc);
                end else begin
                    e = q.pop_front();
                    chk("instr_pc", instr_pc, e);
                    chk("instr_data", instr_data, tag(e));
                end
            end
            if (rst && chk2 && instr_valid2 && instr_ready) begin
                acc2++;
                if (q2.size() == 0) begin
                    total_n++;
                    $display("FAIL extra_output2: got pc %h required none", instr_pc2);
                end else begin
                    e = q2.pop_front();
                    chk("instr_pc2", instr_pc2, e);
                    chk("instr_data2", instr_data2, tag(e));
                end
            end
        end
    end

    task automatic tst_discard(input bit twice);
        logic [31:0] b;
        b = twice ? 32'h300 : 32'h100;
        do_reset(1, 1'b1);
        q.push_back(32'h0);
        q.push_back(32'h4);
        exp_seq(b, 4);
        step(2);
        lat = 4;
        step(1);
        redirect = 1'b1;
        redirect_pc = 32'h103;
        step(1);
        chk("discard_addr", imem_addr, 32'h8);
        chk("discard_req", imem_req, 1);
        chk("flush_count", fifo_count, 0);
        chk("flush_valid", instr_valid, 0);
        redirect = 1'b0;
        lat = 1;
        step(1);
        if (twice) begin
            redirect = 1'b1;
            redirect_pc = 32'h301;
        end
        step(1);
        redirect = 1'b0;
        chk("discard_hold", imem_addr, 32'h8);
        step(1);
        chk("refetch_addr", imem_addr, b);
        chk("drop_valid", instr_valid, 0);
        step(3);
        chk("discard_accepts", acc, 4);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_count", fifo_count, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_addr2", imem_addr2, 32'hFFFF_FFFC);

        // Streaming at full rate, plus PC wrap on the second instance
        do_reset(1, 1'b1);
        exp_seq(32'h0, 8);
        for (int i = 0; i < 8; i++) q2.push_back(32'hFFFF_FFFC + 32'(4 * i));
        chk2 = 1'b1;
        step(1);
        chk("first_req", imem_req, 1);
        chk("first_addr", imem_addr, 32'h0);
        step(5);
        chk("stream_accepts", acc, 4);
        chk("stream_pc", instr_pc, 32'h10);
        chk("stream_count", fifo_count, 1);
        chk("wrap_accepts", acc2, 4);
        chk("wrap_pc", instr_pc2, 32'hC);
        chk2 = 1'b0;

        // Buffer fills with the consumer stalled
        do_reset(1, 1'b0);
        exp_seq(32'h0, 5);
        step(6);
        chk("full_count", fifo_count, 4);
        chk("full_req", imem_req, 0);
        chk("full_accepts", acc, 0);
        instr_ready = 1'b1;
        step(1);
        instr_ready = 1'b0;
        chk("drain_count", fifo_count, 3);
        chk("drain_req", imem_req, 1);
        chk("drain_addr", imem_addr, 32'h10);
        chk("drain_accepts", acc, 1);

        tst_discard(1'b0);
        tst_discard(1'b1);

        // Redirect coinciding with a response
        do_reset(1, 1'b0);
        exp_seq(32'h200, 4);
        step(3);
        chk("pre_redir_count", fifo_count, 2);
        redirect = 1'b1;
        redirect_pc = 32'h200;
        step(1);
        redirect = 1'b0;
        chk("redir_count", fifo_count, 0);
        chk("redir_addr", imem_addr, 32'h200);
        chk("redir_req", imem_req, 1);
        chk("redir_valid", instr_valid, 0);
        instr_ready = 1'b1;
        step(3);
        chk("redir_accepts", acc, 2);

        // Reset mid-request with responses arriving during and after reset
        do_reset(4, 1'b1);
        exp_seq(32'h0, 4);
        step(1);
        chk("inflight_req", imem_req, 1);
        rst = 1'b0;
        #1;
        chk("async_req", imem_req, 0);
        chk("async_addr", imem_addr, 32'h0);
        chk("async_count", fifo_count, 0);
        chk("async_valid", instr_valid, 0);
        stray = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("release_valid", instr_valid, 0);
        @(posedge clk);
        stray = 1'b0;
        lat = 1;
        #2;
        chk("stray_valid", instr_valid, 0);
        chk("stray_count", fifo_count, 0);
        chk("restart_req", imem_req, 1);
        chk("restart_addr", imem_addr, 32'h0);
        step(3);
        chk("restart_accepts", acc, 2);

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
